// File: rtl/nlp_table_pkg.sv
// -----------------------------------------------------------------------------
// nlp_table_pkg
//
// Types shared between the fetch stage, the IF3 pre-decode/redirect stage and
// the next-line predictor storage:
//   NLPInfo        per-slot prediction delivered with each fetch slot
//   NLPUpdateInfo  training record produced by IF3
//   bim_next()     2-bit saturating bimodal counter step
//   clr_state_e    states of the table's self-clearing sweep
// -----------------------------------------------------------------------------
package nlp_table_pkg;

    localparam int unsigned NLP_ENTRIES_DEFAULT  = 64;
    localparam int unsigned NLP_TAG_BITS_DEFAULT = 8;

    localparam logic [1:0] BIM_MAX = 2'b11;
    localparam logic [1:0] BIM_MIN = 2'b00;

    typedef enum logic {
        CLR_CLEAR = 1'b0,
        CLR_READY = 1'b1
    } clr_state_e;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] target;
        logic [1:0]  bimState;
    } NLPInfo;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  bimState;
        logic        shouldTake;
        logic        valid;
    } NLPUpdateInfo;

    localparam NLPInfo NLP_MISS = '0;

    // Saturating step of the bimodal counter. The step is always taken from
    // the counter value that travelled with the instruction, never from the
    // value currently stored in the table.
    function automatic logic [1:0] bim_next(input logic [1:0] state, input logic take);
        logic [1:0] result;
        if (take) begin
            result = (state == BIM_MAX) ? BIM_MAX : state + 2'd1;
        end else begin
            result = (state == BIM_MIN) ? BIM_MIN : state - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/nlp_clear_fsm.sv
// -----------------------------------------------------------------------------
// nlp_clear_fsm
//
// Sweeps the predictor table after reset or on request, invalidating one entry
// per cycle, and reports when the table is usable.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset; restarts the sweep at entry 0
//   clear_req  one-cycle pulse; restarts the sweep at entry 0 from any state
//   ready      high only once every entry has been invalidated
//   clr_en     an entry is being invalidated this cycle
//   clr_idx    index of the entry being invalidated
// -----------------------------------------------------------------------------
module nlp_clear_fsm
    import nlp_table_pkg::*;
#(
    parameter int unsigned ENTRIES = NLP_ENTRIES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_req,
    output logic                       ready,
    output logic                       clr_en,
    output logic [$clog2(ENTRIES)-1:0] clr_idx
);

    localparam int unsigned IDX = $clog2(ENTRIES);
    localparam logic [IDX-1:0] LAST_IDX = IDX'(ENTRIES - 1);

    clr_state_e     state_reg;
    logic [IDX-1:0] clr_cnt_reg;
    logic           ready_reg;

    // ready is registered alongside the state so it is a clean flop output.
    // Entering READY coincides with the edge that invalidates the last entry,
    // so the first ready cycle is exactly ENTRIES edges after the restart edge.
    always_ff @(posedge clk) begin
        if (rst || clear_req) begin
            state_reg   <= CLR_CLEAR;
            clr_cnt_reg <= '0;
            ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                CLR_CLEAR: begin
                    // The counter wraps back to 0 after the last entry.
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == LAST_IDX) begin
                        state_reg <= CLR_READY;
                        ready_reg <= 1'b1;
                    end
                end
                CLR_READY: begin
                    state_reg <= CLR_READY;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg   <= CLR_CLEAR;
                    clr_cnt_reg <= '0;
                    ready_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = ready_reg;
    assign clr_en  = (state_reg == CLR_CLEAR);
    assign clr_idx = clr_cnt_reg;

endmodule

// File: rtl/nlp_table.sv
// -----------------------------------------------------------------------------
// nlp_table
//
// Next-line predictor storage for the two-wide fetch pipeline. Each fetch PC
// is answered one cycle later for the instructions at pc and pc+4. The IF3
// update stream trains a 2-bit bimodal counter and a target per entry.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   clear_req                   restart the invalidation sweep
//   ready                       table initialised and usable
//   lookup_en, lookup_pc        capture a lookup for slots pc and pc+4
//   nlp{0,1}_valid/taken/target/bim
//                               registered per-slot prediction, held while
//                               lookup_en is low
//   upd_valid, upd_pc, upd_target, upd_bim_state, upd_should_take
//                               training update from IF3
// -----------------------------------------------------------------------------
module nlp_table
    import nlp_table_pkg::*;
#(
    parameter int unsigned ENTRIES  = NLP_ENTRIES_DEFAULT,
    parameter int unsigned TAG_BITS = NLP_TAG_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_req,
    output logic        ready,

    input  logic        lookup_en,
    input  logic [31:0] lookup_pc,
    output logic        nlp0_valid,
    output logic        nlp0_taken,
    output logic [31:0] nlp0_target,
    output logic [1:0]  nlp0_bim,
    output logic        nlp1_valid,
    output logic        nlp1_taken,
    output logic [31:0] nlp1_target,
    output logic [1:0]  nlp1_bim,

    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic [1:0]  upd_bim_state,
    input  logic        upd_should_take
);

    localparam int unsigned IDX     = $clog2(ENTRIES);
    localparam int unsigned TAG_LO  = IDX + 2;
    localparam int unsigned TAG_HI  = IDX + TAG_BITS + 1;
    localparam int unsigned SLOTS   = 2;

    // ------------------------------------------------------------------
    // Storage: flop arrays, asynchronous reads, one write port.
    // Only valid is ever cleared; the other fields are don't-care until
    // an allocation writes them.
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0]  valid_reg;
    logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
    logic [31:0]         target_mem [ENTRIES];
    logic [1:0]          bim_mem    [ENTRIES];

    // ------------------------------------------------------------------
    // Clear sweep
    // ------------------------------------------------------------------
    logic           clr_en;
    logic [IDX-1:0] clr_idx;

    nlp_clear_fsm #(
        .ENTRIES (ENTRIES)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .ready     (ready),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx)
    );

    // ------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------
    NLPUpdateInfo        upd;
    logic [IDX-1:0]      upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_hit;
    logic                upd_accept;
    logic                wr_alloc;
    logic                wr_train;
    logic [1:0]          upd_bim_new;
    logic                unused_upd_pc_bits;

    assign upd = '{
        pc:         upd_pc,
        target:     upd_target,
        bimState:   upd_bim_state,
        shouldTake: upd_should_take,
        valid:      upd_valid
    };

    assign upd_idx     = upd.pc[IDX+1:2];
    assign upd_tag     = upd.pc[TAG_HI:TAG_LO];
    assign upd_hit     = valid_reg[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    assign upd_bim_new = bim_next(upd.bimState, upd.shouldTake);

    // Updates are dropped while the table is clearing and when a clear is
    // requested in the same cycle, so a write never races the sweep.
    assign upd_accept = upd.valid && ready && !clear_req;

    // Taken updates allocate unconditionally; not-taken updates only retrain
    // the counter of an entry that already belongs to this PC.
    assign wr_alloc = upd_accept && upd.shouldTake;
    assign wr_train = upd_accept && !upd.shouldTake && upd_hit;

    assign unused_upd_pc_bits = ^{upd.pc[1:0], upd.pc[31:TAG_HI+1]};

    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_reg[clr_idx] <= 1'b0;
        end
        if (wr_alloc) begin
            valid_reg[upd_idx]  <= 1'b1;
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= upd.target;
            bim_mem[upd_idx]    <= upd_bim_new;
        end else if (wr_train) begin
            bim_mem[upd_idx]    <= upd_bim_new;
        end
    end

    // ------------------------------------------------------------------
    // Lookup slots. Slot gi reads the entry for lookup_pc + 4*gi. Deriving
    // both index and tag from that sum gives the (idx0+1) mod ENTRIES wrap
    // for free and lets a carry out of the index land in the tag.
    // Reads see pre-write contents: there is no update-to-lookup bypass.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [31:0]         pc_slot;
            logic [IDX-1:0]      idx_slot;
            logic [TAG_BITS-1:0] tag_slot;
            logic                hit_slot;
            logic                unused_pc_bits;
            NLPInfo              info_next;
            NLPInfo              info_reg;

            assign pc_slot        = lookup_pc + (32'(gi) << 2);
            assign idx_slot       = pc_slot[IDX+1:2];
            assign tag_slot       = pc_slot[TAG_HI:TAG_LO];
            assign unused_pc_bits = ^{pc_slot[1:0], pc_slot[31:TAG_HI+1]};

            // ready is sampled at capture time, so a lookup issued during the
            // sweep reports a miss even if the sweep finishes before the
            // output cycle.
            assign hit_slot = ready && valid_reg[idx_slot] &&
                              (tag_mem[idx_slot] == tag_slot);

            always_comb begin
                info_next = NLP_MISS;
                if (hit_slot) begin
                    info_next.valid    = 1'b1;
                    info_next.taken    = bim_mem[idx_slot][1];
                    info_next.target   = target_mem[idx_slot];
                    info_next.bimState = bim_mem[idx_slot];
                end
            end

            // Output registers hold through fetch stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    info_reg <= NLP_MISS;
                end else if (lookup_en) begin
                    info_reg <= info_next;
                end
            end
        end
    endgenerate

    assign nlp0_valid  = g_slot[0].info_reg.valid;
    assign nlp0_taken  = g_slot[0].info_reg.taken;
    assign nlp0_target = g_slot[0].info_reg.target;
    assign nlp0_bim    = g_slot[0].info_reg.bimState;

    assign nlp1_valid  = g_slot[1].info_reg.valid;
    assign nlp1_taken  = g_slot[1].info_reg.taken;
    assign nlp1_target = g_slot[1].info_reg.target;
    assign nlp1_bim    = g_slot[1].info_reg.bimState;

endmodule
